// File: rtl/gpi_pkg.sv
// Shared constants and types for the board GPI input conditioner.
package gpi_pkg;

    // {BTN, SW} as presented on the board: 16 switches, then 4 buttons.
    localparam int BasysGpiWidth         = 20;
    localparam int SwLsb                 = 0;
    localparam int SwWidth               = 16;
    localparam int BtnLsb                = 16;
    localparam int BtnWidth              = 4;

    // 1 ms of required stability at 50 MHz.
    localparam int DefaultDebounceCycles = 50000;
    localparam int DefaultSyncStages     = 2;

    // Edge event carried by each bit slice. Rise and fall are mutually
    // exclusive because a slice accepts at most one level change per cycle.
    typedef struct packed {
        logic rise;
        logic fall;
    } gpi_evt_t;

endpackage : gpi_pkg

// File: rtl/gpi_debounce_bit.sv
// One GPI input: pad synchroniser, consecutive-sample filter, stable level
// flop and registered rise/fall pulses. evt_nxt_o exposes the pulse that
// will be visible next cycle so the parent can register an aggregate flag
// that lines up with the pulses.
module gpi_debounce_bit
    import gpi_pkg::*;
#(
    parameter int SyncStages     = DefaultSyncStages,      // >= 2
    parameter int DebounceCycles = DefaultDebounceCycles,  // >= 1
    parameter int CntWidth       = $clog2(DebounceCycles + 1)
) (
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
    input  logic raw_i,
    output logic gp_o,
    output logic rise_o,
    output logic fall_o,
    output logic evt_nxt_o
);

    // Last count value before a differing level is accepted.
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_q;
    logic                  s;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  gp_q, gp_d;
    gpi_evt_t              evt_q, evt_d;

    // Plain flop chain; nothing may sit between stages or metastability
    // settling time is eaten.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], raw_i};
        end
    end

    assign s = sync_q[SyncStages-1];

    // Filter: any agreeing sample restarts the count; DebounceCycles
    // consecutive disagreeing samples flip the stable level and raise
    // exactly one event for the following cycle.
    always_comb begin
        cnt_d = cnt_q;
        gp_d  = gp_q;
        evt_d = '0;
        if (s == gp_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d      = '0;
            gp_d       = s;
            evt_d.rise = s;
            evt_d.fall = ~s;
        end else begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    // Filter state and pulse registers; reset drops any count in progress.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            cnt_q <= '0;
            gp_q  <= 1'b0;
            evt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            gp_q  <= gp_d;
            evt_q <= evt_d;
        end
    end

    assign gp_o      = gp_q;
    assign rise_o    = evt_q.rise;
    assign fall_o    = evt_q.fall;
    assign evt_nxt_o = evt_d.rise | evt_d.fall;

endmodule : gpi_debounce_bit

// File: rtl/gpi_debounce.sv
// Board GPI conditioner: Width independent debounced inputs plus an
// aggregate change flag suitable as an interrupt source. Sits between the
// {BTN, SW} pads and the system gp_i port.
module gpi_debounce
    import gpi_pkg::*;
#(
    parameter int Width          = BasysGpiWidth,
    parameter int SyncStages     = DefaultSyncStages,      // >= 2
    parameter int DebounceCycles = DefaultDebounceCycles   // >= 1
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] raw_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic             changed_o
);

    // Sized so DebounceCycles-1 always fits; the counter cannot wrap.
    localparam int CntWidth = $clog2(DebounceCycles + 1);

    logic [Width-1:0] evt_nxt;
    logic             changed_q;

    for (genvar i = 0; i < Width; i++) begin : g_bit
        gpi_debounce_bit #(
            .SyncStages     (SyncStages),
            .DebounceCycles (DebounceCycles),
            .CntWidth       (CntWidth)
        ) u_bit (
            .clk_sys_i (clk_sys_i),
            .rst_sys_ni(rst_sys_ni),
            .raw_i     (raw_i[i]),
            .gp_o      (gp_o[i]),
            .rise_o    (rise_o[i]),
            .fall_o    (fall_o[i]),
            .evt_nxt_o (evt_nxt[i])
        );
    end

    // Register the OR of next-cycle events so changed_o is glitch-free yet
    // coincides with the rise/fall pulses it summarises.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |evt_nxt;
        end
    end

    assign changed_o = changed_q;

endmodule : gpi_debounce

// File: tb/tb_gpi_debounce.sv
// Bench for gpi_debounce: directed vectors, a sliding-window model checked
// every cycle, and hand-computed expectations at the interesting edges.
module tb_gpi_debounce;

    localparam int W  = 20;
    localparam int SS = 2;
    localparam int N  = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] raw   = '0;
    logic [W-1:0] gp_o, rise_o, fall_o;
    logic         changed_o;

    int checks = 0;
    int errors = 0;

    gpi_debounce #(
        .Width         (W),
        .SyncStages    (SS),
        .DebounceCycles(N)
    ) dut (
        .clk_sys_i (clk),
        .rst_sys_ni(rst_n),
        .raw_i     (raw),
        .gp_o      (gp_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .changed_o (changed_o)
    );

    always #5 clk = ~clk;

    // Model: the filter input at edge k is the pad level from edge k-SS.
    // A bit flips when its last N filter inputs all differ from its level.
    logic [W-1:0] raw_hist[$];
    logic [W-1:0] s_hist[$];
    logic [W-1:0] gp_m   = '0;
    logic [W-1:0] rise_m = '0;
    logic [W-1:0] fall_m = '0;
    logic         chg_m  = 1'b0;
    logic [W-1:0] s_k, flip;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_hist.delete();
            s_hist.delete();
            gp_m   <= '0;
            rise_m <= '0;
            fall_m <= '0;
            chg_m  <= 1'b0;
        end else begin
            raw_hist.push_back(raw);
            if (raw_hist.size() > 16) void'(raw_hist.pop_front());
            s_k = (raw_hist.size() > SS) ? raw_hist[raw_hist.size() - 1 - SS] : '0;
            s_hist.push_back(s_k);
            if (s_hist.size() > 16) void'(s_hist.pop_front());
            flip = (s_hist.size() >= N) ? '1 : '0;
            for (int j = 0; j < N; j++)
                if (s_hist.size() >= N)
                    flip = flip & (s_hist[s_hist.size() - 1 - j] ^ gp_m);
            rise_m <= flip & ~gp_m;
            fall_m <= flip & gp_m;
            gp_m   <= gp_m ^ flip;
            chg_m  <= |flip;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Advance one cycle; compare DUT against the model at the negedge,
    // then return 1 time unit later so stimulus never races the compare.
    task automatic tick();
        @(negedge clk);
        checks++;
        if ({gp_o, rise_o, fall_o, changed_o} !== {gp_m, rise_m, fall_m, chg_m}) begin
            errors++;
            $display("FAIL model_cmp at %0t: gp=%h/%h rise=%h/%h fall=%h/%h chg=%b/%b (dut/model)",
                     $time, gp_o, gp_m, rise_o, rise_m, fall_o, fall_m, changed_o, chg_m);
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    logic [W-1:0] seen;
    logic [5:0]   pat;

    initial begin
        // Power-up with all inputs held high through reset.
        raw = 20'hFFFFF;
        ticks(3);
        chk("reset_gp", gp_o, 0);
        chk("reset_rise", rise_o, 0);
        chk("reset_fall", fall_o, 0);
        chk("reset_chg", changed_o, 0);
        rst_n = 1'b1;
        ticks(5);
        chk("pwr_gp_e5", gp_o, 0);
        tick();
        chk("pwr_gp_e6", gp_o, 20'hFFFFF);
        chk("pwr_rise_e6", rise_o, 20'hFFFFF);
        chk("pwr_fall_e6", fall_o, 0);
        chk("pwr_chg_e6", changed_o, 1);
        chk("pwr_model_e6", gp_m, 20'hFFFFF);
        tick();
        chk("pwr_rise_e7", rise_o, 0);
        chk("pwr_chg_e7", changed_o, 0);

        // Clean baseline at zero, then a clean step on bit 3.
        rst_n = 1'b0;
        raw   = '0;
        ticks(2);
        rst_n = 1'b1;
        ticks(8);
        raw = 20'h00008;
        ticks(5);
        chk("b3_gp_e5", gp_o, 0);
        tick();
        chk("b3_gp_e6", gp_o, 20'h00008);
        chk("b3_rise_e6", rise_o, 20'h00008);
        chk("b3_fall_e6", fall_o, 0);
        tick();
        chk("b3_rise_e7", rise_o, 0);

        // Bit 7 glitch, one sample short of acceptance.
        seen = '0;
        raw  = 20'h00088;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen = seen | rise_o | fall_o | {{(W-1){1'b0}}, changed_o};
        end
        raw = 20'h00008;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen = seen | rise_o | fall_o | {{(W-1){1'b0}}, changed_o};
        end
        chk("glitch_events", seen, 0);
        chk("glitch_gp", gp_o, 20'h00008);

        // Bit 0 bounce 1,0,1,1,1,1 then held high.
        pat = 6'b111101;
        for (int k = 0; k < 6; k++) begin
            raw[0] = pat[k];
            tick();
        end
        tick();
        chk("bounce_gp_a7", gp_o, 20'h00008);
        tick();
        chk("bounce_gp_a8", gp_o, 20'h00009);
        chk("bounce_rise_a8", rise_o, 20'h00001);

        // Bits 2 and 19 rise, settle, then fall together.
        raw = 20'h8000D;
        ticks(10);
        chk("pair_gp_high", gp_o, 20'h8000D);
        raw = 20'h00009;
        ticks(5);
        chk("pair_chg_e5", changed_o, 0);
        chk("pair_fall_e5", fall_o, 0);
        tick();
        chk("pair_fall_e6", fall_o, 20'h80004);
        chk("pair_rise_e6", rise_o, 0);
        chk("pair_chg_e6", changed_o, 1);
        chk("pair_gp_e6", gp_o, 20'h00009);
        tick();
        chk("pair_fall_e7", fall_o, 0);
        chk("pair_chg_e7", changed_o, 0);

        // Reset mid-count on bit 5 (count is 2 after the fourth edge).
        raw = 20'h00029;
        ticks(4);
        chk("midrst_gp_before", gp_o, 20'h00009);
        rst_n = 1'b0;
        #1;
        chk("midrst_gp", gp_o, 0);
        chk("midrst_rise", rise_o, 0);
        chk("midrst_fall", fall_o, 0);
        chk("midrst_chg", changed_o, 0);
        ticks(2);
        rst_n = 1'b1;
        ticks(5);
        chk("midrst_gp_e5", gp_o, 0);
        tick();
        chk("midrst_gp_e6", gp_o, 20'h00029);
        chk("midrst_rise_e6", rise_o, 20'h00029);
        chk("midrst_chg_e6", changed_o, 1);
        chk("midrst_model_e6", gp_m, 20'h00029);
        ticks(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule : tb_gpi_debounce
